// File: rtl/ps2_port_controller_pkg.sv
// Shared constants and port decode for the AT-style keyboard port block.
package ps2_port_controller_pkg;

    localparam logic [15:0] PORT_KBD_DATA   = 16'h0060;
    localparam logic [15:0] PORT_KBD_CTRL   = 16'h0061;
    localparam logic [15:0] PORT_KBD_STATUS = 16'h0064;

    localparam logic [7:0]  FIFO_FLUSH_CMD  = 8'hFF;
    localparam logic [7:0]  UNMAPPED_BYTE   = 8'hFF;
    localparam int          BYTE_W          = 8;

    localparam int OBF = 0;
    localparam int OVF = 1;

    localparam int STB_WRITE = 0;
    localparam int STB_READ  = 1;
    localparam int STB_PS2   = 2;
    localparam int NUM_STB   = 3;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_DATA,
        REG_CTRL,
        REG_STATUS
    } reg_sel_e;

    function automatic reg_sel_e decode_port(input logic [15:0] addr);
        case (addr)
            PORT_KBD_DATA:   return REG_DATA;
            PORT_KBD_CTRL:   return REG_CTRL;
            PORT_KBD_STATUS: return REG_STATUS;
            default:         return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular scancode buffer with push/pop/flush; a push while full is accepted
// only when a pop frees a slot in the same cycle, otherwise the byte is dropped.
module sync_fifo
    import ps2_port_controller_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] push_dat_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [BYTE_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i & ~empty_o & ~flush_i;
        do_push  = push_i & (~full_o | do_pop | flush_i);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush discards everything queued; a same-cycle push lands after it.
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_d + CNT_ONE;
            2'b01:   count_d = count_d - CNT_ONE;
            default: count_d = count_d;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/ps2_port_controller.sv
// CPU port decoder exposing a PS/2 scancode FIFO at 0x60/0x61/0x64.
// Strobes are synchronised and act once on their rising edge, two clocks late.
module ps2_port_controller
    import ps2_port_controller_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] port_addr,
    output logic [15:0] port_in,
    input  logic [15:0] port_out,
    input  logic        port_bit,
    input  logic        port_clk,
    input  logic        port_read,
    input  logic [7:0]  ps2_data,
    input  logic        ps2_data_clk
);

    logic [NUM_STB-1:0] stb_raw;
    logic [NUM_STB-1:0] meta_q, sync_q, prev_q;
    logic [NUM_STB-1:0] armed_q, armed_d;
    logic [NUM_STB-1:0] fire;
    logic [1:0]         live_q;

    logic [15:0] port_in_q, port_in_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  last_q, last_d;
    logic        ovf_q, ovf_d;

    reg_sel_e    lo_sel, hi_sel;
    logic        wr_fire, rd_fire, push;
    logic        flush, pop, status_rd, overflow, empty_v;
    logic [7:0]  data_v, status_v, lo_byte, hi_byte;
    logic [7:0]  fifo_head;
    logic        fifo_full, fifo_empty;

    assign stb_raw = {ps2_data_clk, port_read, port_clk};
    assign port_in = port_in_q;

    // A strobe may fire only after its synchronised level has been seen low
    // post-reset, so a strobe held high across reset release is ignored.
    always_comb begin
        armed_d = armed_q | ({NUM_STB{live_q[1]}} & ~sync_q);
        fire    = sync_q & ~prev_q & armed_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            live_q  <= '0;
        end else begin
            meta_q  <= stb_raw;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            armed_q <= armed_d;
            live_q  <= {live_q[0], 1'b1};
        end
    end

    function automatic logic [7:0] reg_byte(input reg_sel_e   sel,
                                            input logic [7:0] data_b,
                                            input logic [7:0] ctrl_b,
                                            input logic [7:0] status_b);
        case (sel)
            REG_DATA:   return data_b;
            REG_CTRL:   return ctrl_b;
            REG_STATUS: return status_b;
            default:    return UNMAPPED_BYTE;
        endcase
    endfunction

    // The write is applied first; the read then sees the post-write state.
    always_comb begin
        wr_fire = fire[STB_WRITE];
        rd_fire = fire[STB_READ];
        push    = fire[STB_PS2];
        lo_sel  = decode_port(port_addr);
        hi_sel  = port_bit ? decode_port(port_addr + 16'd1) : REG_NONE;

        ctrl_d = ctrl_q;
        flush  = 1'b0;
        if (wr_fire) begin
            if (lo_sel == REG_CTRL) ctrl_d = port_out[7:0];
            if (hi_sel == REG_CTRL) ctrl_d = port_out[15:8];
            flush = ((lo_sel == REG_STATUS) && (port_out[7:0]  == FIFO_FLUSH_CMD)) ||
                    ((hi_sel == REG_STATUS) && (port_out[15:8] == FIFO_FLUSH_CMD));
        end

        empty_v       = fifo_empty | flush;
        data_v        = empty_v ? last_q : fifo_head;
        status_v      = '0;
        status_v[OBF] = ~empty_v;
        status_v[OVF] = ovf_q & ~flush;

        pop       = rd_fire & ~empty_v & ((lo_sel == REG_DATA) || (hi_sel == REG_DATA));
        status_rd = rd_fire & ((lo_sel == REG_STATUS) || (hi_sel == REG_STATUS));
        overflow  = push & fifo_full & ~pop & ~flush;

        last_d = pop ? fifo_head : last_q;
        ovf_d  = (status_v[OVF] & ~status_rd) | overflow;

        lo_byte   = reg_byte(lo_sel, data_v, ctrl_d, status_v);
        hi_byte   = port_bit ? reg_byte(hi_sel, data_v, ctrl_d, status_v) : 8'h00;
        port_in_d = rd_fire ? {hi_byte, lo_byte} : port_in_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_in_q <= '0;
            ctrl_q    <= '0;
            last_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            port_in_q <= port_in_d;
            ctrl_q    <= ctrl_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (push),
        .push_dat_i (ps2_data),
        .pop_i      (pop),
        .flush_i    (flush),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: tb/tb_ps2_port_controller.sv
// Scoreboard bench: a behavioural model queues each expected read result.
module tb_ps2_port_controller;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] port_addr;
    logic [15:0] port_in;
    logic [15:0] port_out;
    logic        port_bit;
    logic        port_clk;
    logic        port_read;
    logic [7:0]  ps2_data;
    logic        ps2_data_clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  m_fifo[$];
    logic        m_ovf;
    logic [7:0]  m_ctrl;
    logic [7:0]  m_last;

    always #10 clk = ~clk;

    ps2_port_controller #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .port_addr    (port_addr),
        .port_in      (port_in),
        .port_out     (port_out),
        .port_bit     (port_bit),
        .port_clk     (port_clk),
        .port_read    (port_read),
        .ps2_data     (ps2_data),
        .ps2_data_clk (ps2_data_clk)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_ovf  = 1'b0;
        m_ctrl = 8'h00;
        m_last = 8'h00;
    endtask

    task automatic model_rd_byte(input logic [15:0] a, output logic [7:0] v);
        case (a)
            16'h0060: begin
                if (m_fifo.size() > 0) begin
                    v = m_fifo.pop_front();
                    m_last = v;
                end else begin
                    v = m_last;
                end
            end
            16'h0061: v = m_ctrl;
            16'h0064: begin
                v = {6'b0, m_ovf, m_fifo.size() != 0};
                m_ovf = 1'b0;
            end
            default:  v = 8'hFF;
        endcase
    endtask

    task automatic model_wr_byte(input logic [15:0] a, input logic [7:0] v);
        if (a == 16'h0061) m_ctrl = v;
        if (a == 16'h0064 && v == 8'hFF) begin
            m_fifo.delete();
            m_ovf = 1'b0;
        end
    endtask

    task automatic model_push(input logic [7:0] v);
        if (m_fifo.size() < DEPTH) m_fifo.push_back(v);
        else m_ovf = 1'b1;
    endtask

    task automatic model_read(input logic [15:0] a, input logic b16);
        logic [7:0] lo, hi;
        model_rd_byte(a, lo);
        hi = 8'h00;
        if (b16) model_rd_byte(a + 16'd1, hi);
        exp_q.push_back({hi, lo});
    endtask

    task automatic ps2_send(input logic [7:0] v);
        model_push(v);
        @(negedge clk);
        ps2_data     = v;
        ps2_data_clk = 1'b1;
        idle(1);
        ps2_data_clk = 1'b0;
        idle(3);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] v, input logic b16);
        model_wr_byte(a, v[7:0]);
        if (b16) model_wr_byte(a + 16'd1, v[15:8]);
        @(negedge clk);
        port_addr = a;
        port_out  = v;
        port_bit  = b16;
        port_clk  = 1'b1;
        idle(3);
        port_clk  = 1'b0;
        idle(3);
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic b16, output logic [15:0] got);
        model_read(a, b16);
        @(negedge clk);
        port_addr = a;
        port_bit  = b16;
        port_read = 1'b1;
        idle(3);
        port_read = 1'b0;
        idle(3);
        got = port_in;
    endtask

    // Read and scancode strobes rise together so both act in the same cycle.
    task automatic read_with_push(input logic [15:0] a, input logic [7:0] v,
                                  output logic [15:0] got);
        model_read(a, 1'b0);
        model_push(v);
        @(negedge clk);
        port_addr    = a;
        port_bit     = 1'b0;
        port_read    = 1'b1;
        ps2_data     = v;
        ps2_data_clk = 1'b1;
        idle(1);
        ps2_data_clk = 1'b0;
        idle(2);
        port_read    = 1'b0;
        idle(3);
        got = port_in;
    endtask

    task automatic test_reset();
        logic [15:0] got, exp;
        rst = 1'b1; port_addr = '0; port_out = '0; port_bit = 1'b0;
        port_clk = 1'b0; port_read = 1'b0; ps2_data = '0; ps2_data_clk = 1'b0;
        model_reset();
        idle(2);
        checks++;
        if (port_in !== 16'h0000) begin
            errors++; $display("FAIL reset_port_in got %h want 0000", port_in);
        end
        rst = 1'b0;
        idle(5);
        cpu_read(16'h0064, 1'b0, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp || got !== 16'h0000) begin
            errors++; $display("FAIL reset_status got %h want %h", got, exp);
        end
    endtask

    task automatic test_empty_read();
        logic [15:0] got, exp;
        cpu_read(16'h0060, 1'b0, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp || got !== 16'h0000) begin
            errors++; $display("FAIL empty_data got %h want %h", got, exp);
        end
        cpu_read(16'h0064, 1'b0, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL empty_status got %h want %h", got, exp);
        end
    endtask

    task automatic test_single_scancode();
        logic [15:0] got, exp;
        logic [15:0] want[3] = '{16'h0001, 16'h0076, 16'h0000};
        logic [15:0] addr[3] = '{16'h0064, 16'h0060, 16'h0064};
        ps2_send(8'h76);
        for (int i = 0; i < 3; i++) begin
            cpu_read(addr[i], 1'b0, got);
            exp = exp_q.pop_front(); checks++;
            if (got !== exp || got !== want[i]) begin
                errors++; $display("FAIL single_%0d got %h want %h", i, got, want[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] got, exp;
        for (int i = 1; i <= 9; i++) ps2_send(8'(i));
        cpu_read(16'h0064, 1'b0, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp || got !== 16'h0003) begin
            errors++; $display("FAIL ovf_status got %h want %h", got, exp);
        end
        for (int i = 1; i <= 9; i++) begin
            cpu_read(16'h0060, 1'b0, got);
            exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL ovf_data_%0d got %h want %h", i, got, exp);
            end
        end
        cpu_read(16'h0064, 1'b0, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp || got !== 16'h0000) begin
            errors++; $display("FAIL ovf_drained got %h want %h", got, exp);
        end
    endtask

    task automatic test_16bit();
        logic [15:0] got, exp;
        logic [15:0] addr[4] = '{16'h0061, 16'h0060, 16'h0063, 16'h0070};
        logic        wide[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        ps2_send(8'h2E);
        cpu_write(16'h0060, 16'hA55A, 1'b1);
        ps2_send(8'h3C);
        for (int i = 0; i < 4; i++) begin
            cpu_read(addr[i], wide[i], got);
            exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL wide_%0d got %h want %h", i, got, exp);
            end
            if (i == 1) begin
                checks++;
                if (got !== 16'hA52E) begin
                    errors++; $display("FAIL wide_a52e got %h want a52e", got);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [15:0] got, exp;
        cpu_read(16'h0060, 1'b0, got);
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) ps2_send(8'h40 + 8'(i));
        cpu_write(16'h0064, 16'h0012, 1'b0);
        cpu_read(16'h0064, 1'b0, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp || got !== 16'h0001) begin
            errors++; $display("FAIL flush_ignored got %h want %h", got, exp);
        end
        cpu_write(16'h0064, 16'h00FF, 1'b0);
        cpu_read(16'h0064, 1'b0, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp || got !== 16'h0000) begin
            errors++; $display("FAIL flush_status got %h want %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got, exp;
        read_with_push(16'h0060, 8'h5C, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL b2b_empty got %h want %h", got, exp);
        end
        for (int i = 0; i < DEPTH; i++) ps2_send(8'h10 + 8'(i));
        read_with_push(16'h0060, 8'h99, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL b2b_full got %h want %h", got, exp);
        end
        for (int i = 0; i <= DEPTH + 1; i++) begin
            cpu_read((i == 0) ? 16'h0064 : 16'h0060, 1'b0, got);
            exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL b2b_drain_%0d got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got, exp;
        ps2_send(8'h21);
        ps2_send(8'h22);
        cpu_read(16'h0061, 1'b0, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL pre_reset_ctrl got %h want %h", got, exp);
        end
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (port_in !== 16'h0000) begin
            errors++; $display("FAIL mid_reset_port_in got %h want 0000", port_in);
        end
        model_reset();
        port_addr = 16'h0070;
        port_bit  = 1'b1;
        port_read = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(4);
        port_read = 1'b0;
        idle(3);
        checks++;
        if (port_in !== 16'h0000) begin
            errors++; $display("FAIL held_strobe got %h want 0000", port_in);
        end
        for (int i = 0; i < 3; i++) begin
            cpu_read((i == 0) ? 16'h0064 : 16'h005F + 16'(i), 1'b0, got);
            exp = exp_q.pop_front(); checks++;
            if (got !== exp || got !== 16'h0000) begin
                errors++; $display("FAIL post_reset_%0d got %h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty_read();
        test_single_scancode();
        test_overflow();
        test_16bit();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
